// File: rtl/student_fir_quant_if.sv
// Output sample stream of the FIR quantiser.
// Valid/ready handshake, first-word-fall-through head.
interface student_fir_quant_if #(
    parameter int DATA_SIZE = 16
);
    logic [DATA_SIZE-1:0] sample_out;
    logic                 valid_out;
    logic                 ready_in;

    modport master (
        output sample_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  sample_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/student_fir_quant.sv
// FIR output stage: capture, round, shift, saturate,
// then buffer in a small FWFT FIFO with status reporting.
module student_fir_quant #(
    parameter int DATA_SIZE  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_strobe_in,
    input  logic [ACC_WIDTH-1:0]        y_in,
    student_fir_quant_if.master         out_if,
    input  logic                        clear_i,
    output logic                        overflow_o,
    output logic [15:0]                 sat_count_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_WIDTH:0] RND =
        (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) << RS) : '0;

    logic                 strobe_prev;
    logic                 start;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 s1_valid;

    logic signed [ACC_WIDTH:0] t_s;
    logic signed [ACC_WIDTH:0] q_s;
    logic                      in_range;
    logic                      sat;
    logic [DATA_SIZE-1:0]      result;

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level_q;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;

    assign start = valid_strobe_in && !strobe_prev;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            strobe_prev <= 1'b0;
            s1_valid    <= 1'b0;
            acc_q       <= '0;
        end else begin
            strobe_prev <= valid_strobe_in;
            s1_valid    <= start;
            if (start) begin
                acc_q <= y_in;
            end
        end
    end

    // One guard bit keeps the rounding add from wrapping at the top.
    always_comb begin
        t_s      = $signed({acc_q[ACC_WIDTH-1], acc_q} + RND);
        q_s      = t_s >>> SHIFT;
        in_range = (&q_s[ACC_WIDTH:DATA_SIZE-1])
                 | (~|q_s[ACC_WIDTH:DATA_SIZE-1]);
        sat      = !in_range;
        result   = q_s[DATA_SIZE-1:0];
        if (!in_range) begin
            result = q_s[ACC_WIDTH]
                   ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                   : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
    end

    assign full = (level_q == LW'(FIFO_DEPTH));
    assign pop  = out_if.valid_out && out_if.ready_in;
    assign push = s1_valid && (!full || pop);
    assign drop = s1_valid && full && !pop;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            sat_count_o <= '0;
        end else if (clear_i) begin
            overflow_o  <= 1'b0;
            sat_count_o <= '0;
        end else begin
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (s1_valid && sat && sat_count_o != 16'hFFFF) begin
                sat_count_o <= sat_count_o + 16'd1;
            end
        end
    end

    assign out_if.sample_out = mem[rd_ptr];
    assign out_if.valid_out  = (level_q != '0);
    assign level_o           = level_q;
endmodule

// File: doc/student_fir_quant.md
Name: student_fir_quant

Overview:
Output stage directly downstream of the FIR accumulator.
- Captures the full-width accumulator result on each rising edge of the FIR's output strobe.
- Rounds, arithmetically shifts and saturates the result to a DATA_SIZE-bit signed sample.
- Buffers samples in a small first-word-fall-through FIFO and presents them on a valid/ready interface to the audio/output path.
- Reports saturation and overflow status for software.

Parameters:
DATA_SIZE, 16, output sample width (signed two's complement)
ACC_WIDTH, 32, accumulator input width; must be >= DATA_SIZE + SHIFT
SHIFT, 15, right-shift applied to the accumulator (coefficient fraction bits); 0 allowed
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  reset, synchronous, active-low
valid_strobe_in  in  1  FIR result strobe; only the rising edge is significant
y_in  in  ACC_WIDTH  FIR accumulator value, signed; valid in the cycle the strobe rises
sample_out  out  DATA_SIZE  FIFO head sample, signed
valid_out  out  1  FIFO not empty
ready_in  in  1  consumer accepts sample_out when valid_out && ready_in
clear_i  in  1  clears overflow_o and sat_count_o
overflow_o  out  1  sticky: a result was dropped because the FIFO was full
sat_count_o  out  16  number of saturated results; holds at 0xFFFF
level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_ni low at a clock edge), values after that edge:
  - pipeline valid flags = 0; FIFO pointers and level = 0
  - valid_out = 0, sample_out = 0, overflow_o = 0, sat_count_o = 0
  - strobe history register = 0, so a strobe already high on the first post-reset cycle counts as a rising edge
  - reset mid-operation discards in-flight and buffered samples
- Edge detect: start = valid_strobe_in && !strobe_prev. A strobe held high for N cycles produces exactly one capture.
- Stage 1, edge E (start = 1): acc_q <= y_in; s1_valid <= 1. Otherwise s1_valid <= 0.
- Stage 2, edge E+1, combinational on acc_q:
  - t = sign-extend(acc_q, ACC_WIDTH+1) + (SHIFT > 0 ? 2^(SHIFT-1) : 0)
  - q = t >>> SHIFT (arithmetic shift); rounding is half-up toward +inf
  - if q > 2^(DATA_SIZE-1)-1, result = 0x7FF…F; if q < -2^(DATA_SIZE-1), result = 0x800…0; either case is a saturation event
  - otherwise result = q[DATA_SIZE-1:0]
  - push result into the FIFO when s1_valid
- Latency: sample visible on sample_out, with valid_out = 1, in the cycle after edge E+1 when the FIFO was empty. Back-to-back strobe rising edges every 2 cycles are sustained.
- FIFO:
  - first-word-fall-through: sample_out = mem[rd_ptr]; valid_out = (level != 0)
  - pop when valid_out && ready_in
  - pointers wrap modulo FIFO_DEPTH; level tracks pushes minus pops
- FIFO boundary conditions:
  - push while full, no pop same cycle: sample dropped, FIFO content unchanged, overflow_o <= 1
  - push while full with pop same cycle: both occur; level unchanged; no overflow
  - push while empty with ready_in = 1: push occurs; pop does not (valid_out was 0); sample appears next cycle
  - ready_in while empty: ignored
- sat_count_o: +1 per saturation event, including events whose sample is dropped by overflow; saturates at 0xFFFF and does not wrap.
- clear_i at an edge: overflow_o <= 0 and sat_count_o <= 0. Clear wins over a simultaneous saturation or overflow event. The FIFO is not flushed.
- No state machine beyond the two pipeline valid flags and FIFO control. sample_out holds its last value while empty, with no requirement on its content.

Test Plan (SHIFT = 15, DATA_SIZE = 16, FIFO_DEPTH = 4):
1. Rounding, positive: y_in = 0x00004000, then y_in = 0x00003FFF on separate strobes, ready_in = 1 -> sample_out = 0x0001, then 0x0000. First sample has valid_out high 2 edges after the strobe edge. sat_count_o = 0.
2. Negative values: y_in = 0xFFFFC000 -> 0x0000; y_in = 0xFFFFBFFF -> 0xFFFF; y_in = 0xFFFF0000 -> 0xFFFE.
3. Saturation: y_in = 0x40000000 -> 0x7FFF; y_in = 0x80000000 -> 0x8000 -> sat_count_o = 2. Then pulse clear_i -> sat_count_o = 0.
4. Overflow: ready_in = 0; 5 strobes, y_in = 1·2^15 … 5·2^15 -> level_o = 4, overflow_o = 1. Then ready_in = 1 -> drains 1,2,3,4 in order, then valid_out = 0.
5. Held strobe: valid_strobe_in high for 10 cycles with y_in = 0x00010000 -> exactly one sample, 0x0002, and level_o peaks at 1.
6. Reset mid-operation: push 2 samples, ready_in = 0; rst_ni low for 1 edge -> valid_out = 0, level_o = 0, overflow_o = 0, sat_count_o = 0. The next strobe gives a correct sample.
